// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle ALU with start/busy/done handshake
// Logic/arith ops finish in two cycles; shifts walk one bit per cycle.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   error
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b1110;
    localparam logic [3:0] OP_SRL = 4'b1100;
    localparam logic [3:0] OP_JR  = 4'b1101;
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    // b_q doubles as the shift work register once a shift is accepted.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = ALUOperation;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = shamt;
                    state_d = (ALUOperation == OP_SLL || ALUOperation == OP_SRL) ? S_SHIFT : S_EXEC;
                end
            end
            S_EXEC: begin
                error_d = 1'b0;
                case (op_q)
                    OP_AND:  result_d = a_q & b_q;
                    OP_OR:   result_d = a_q | b_q;
                    OP_NOR:  result_d = ~(a_q | b_q);
                    OP_ADD:  result_d = a_q + b_q;
                    OP_SUB:  result_d = a_q - b_q;
                    OP_JR:   result_d = a_q;
                    default: begin
                        result_d = '0;
                        error_d  = 1'b1;
                    end
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    b_d   = (op_q == OP_SLL) ? (b_q << 1) : (b_q >> 1);
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    result_d = b_q;
                    error_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign error     = error_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - randomized self-checking bench for multicycle_alu
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        busy, done, Zero, error;
    logic [31:0] ALUResult;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: what the op means, and how many cycles after start done shows.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic e, output int lat);
        e   = 1'b0;
        lat = 2;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = ~(a | b);
            4'd3:  r = a + b;
            4'd4:  r = a - b;
            4'd14: begin r = b << sh; lat = int'(sh) + 2; end
            4'd12: begin r = b >> sh; lat = int'(sh) + 2; end
            4'd13: r = a;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input bit poke);
        logic [31:0] er;
        logic        ee;
        int          lat, n, busy_cnt;
        bit          seen;
        model(op, a, b, sh, er, ee, lat);
        @(negedge clk);
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
        n = 0; busy_cnt = 0; seen = 0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
            start = (poke && !seen && (n % 2 == 1));
            A = $urandom; B = $urandom; shamt = 5'($urandom);
            ALUOperation = 4'($urandom);
        end
        start = 1'b0;
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, n, lat);
        check({tag, "_busycnt"}, busy_cnt, lat - 1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_res"}, ALUResult, er);
        check({tag, "_err"}, 32'(error), 32'(ee));
        check({tag, "_zero"}, 32'(Zero), 32'(er == 32'd0));
    endtask

    initial begin
        int dcount;
        int n;
        reset = 1'b1; start = 1'b0; ALUOperation = '0; A = '0; B = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd1);
        check("rst_err", 32'(error), 32'd0);
        reset = 1'b0;

        // Abort an SLL mid-flight with an asynchronous reset.
        run_op("pre_jr", 4'd13, 32'h1234_5678, 32'h0, 5'd0, 0);
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'd14; A = 32'h0; B = 32'h8000_0001; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", ALUResult, 32'd0);
        check("abort_zero", 32'(Zero), 32'd1);
        check("abort_err", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_nodone", dcount, 0);
        run_op("add34", 4'd3, 32'd3, 32'd4, 5'd0, 0);

        run_op("and", 4'd0, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("or", 4'd1, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("nor", 4'd2, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("add", 4'd3, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("sub", 4'd4, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("jr", 4'd13, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        run_op("inv9", 4'd9, 32'hF0F0_00FF, 32'h0F0F_00F0, 5'd7, 0);
        check("sweep_const", ALUResult, 32'h0);
        run_op("addwrap", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        run_op("sub55", 4'd4, 32'd5, 32'd5, 5'd0, 0);
        run_op("sub01", 4'd4, 32'd0, 32'd1, 5'd0, 0);
        check("sub01_const", ALUResult, 32'hFFFF_FFFF);
        run_op("sll4", 4'd14, 32'h0, 32'h8000_0001, 5'd4, 0);
        check("sll4_const", ALUResult, 32'h0000_0010);
        run_op("srl31", 4'd12, 32'h0, 32'h8000_0001, 5'd31, 0);
        run_op("sll0", 4'd14, 32'h0, 32'h8000_0001, 5'd0, 0);
        run_op("poke_sll", 4'd14, 32'h0, 32'h0000_00F3, 5'd10, 1);
        run_op("poke_sub", 4'd4, 32'd100, 32'd58, 5'd0, 1);

        // start held high: the ADD is only taken in the SRL's done cycle.
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'd12; A = 32'h0; B = 32'h8000_0001; shamt = 5'd3;
        n = 0; dcount = 0;
        while (n < 7) begin
            @(negedge clk);
            n++;
            if (n == 1) begin ALUOperation = 4'd3; A = 32'd10; B = 32'd20; shamt = 5'd0; end
            if (done) dcount++;
            if (n == 4) check("b2b_nodone4", 32'(done), 32'd0);
            if (n == 5) begin
                check("b2b_done1", 32'(done), 32'd1);
                check("b2b_res1", ALUResult, 32'h1000_0000);
            end
            if (n == 6) begin
                check("b2b_busy2", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (n == 7) begin
                check("b2b_done2", 32'(done), 32'd1);
                check("b2b_res2", ALUResult, 32'd30);
            end
        end
        check("b2b_count", dcount, 2);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 3))
                0: op = 4'd14;
                1: op = 4'd12;
                default: op = 4'($urandom);
            endcase
            run_op("rnd", op, $urandom, $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
